// File: rtl/mac_stream_feeder.sv
// rtl/mac_stream_feeder.sv - beat FIFO and sequencer feeding one MAC array dot product
module mac_stream_feeder #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16,
  parameter int MAC_LAT    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [255:0]     in_data,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic [15:0]      bias_in,
  output logic             busy,
  output logic [63:0]      DMA_channel_0,
  output logic [63:0]      DMA_channel_1,
  output logic [63:0]      DMA_channel_2,
  output logic [63:0]      DMA_channel_3,
  output logic             en,
  output logic             clr,
  output logic             read_en,
  output logic [15:0]      bias,
  input  logic [15:0]      dot_product,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [LW-1:0] LAT_LAST = LW'(MAC_LAT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESULT} state_t;

  state_t           state_q;
  logic [255:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [LEN_W-1:0] vec_len_q, beat_cnt_q;
  logic [LW-1:0]    lat_cnt_q;
  logic [15:0]      bias_q, res_data_q;
  logic [63:0]      ch0_q, ch1_q, ch2_q, ch3_q;
  logic             en_q, clr_q, read_en_q, res_valid_q;
  logic             full, empty, push, pop;
  logic [255:0]     fifo_rdata;

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign push       = in_valid && !full;
  assign pop        = (state_q == STREAM) && !empty && (beat_cnt_q != vec_len_q);
  assign fifo_rdata = mem_q[rd_ptr_q];

  // Occupancy next-state: simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  // Beat storage; contents need no reset because the pointers gate every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Sequencer with registered MAC-side and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_len_q   <= '0;
      beat_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      bias_q      <= '0;
      res_data_q  <= '0;
      ch0_q       <= '0;
      ch1_q       <= '0;
      ch2_q       <= '0;
      ch3_q       <= '0;
      en_q        <= 1'b0;
      clr_q       <= 1'b0;
      read_en_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      en_q  <= 1'b0;
      clr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            vec_len_q  <= vec_len;
            bias_q     <= bias_in;
            beat_cnt_q <= '0;
            clr_q      <= 1'b1;
            state_q    <= CLEAR;
          end
        end
        CLEAR: begin
          lat_cnt_q <= '0;
          if (vec_len_q == '0) begin
            read_en_q <= 1'b1;
            state_q   <= DRAIN;
          end else begin
            state_q   <= STREAM;
          end
        end
        STREAM: begin
          if (beat_cnt_q == vec_len_q) begin
            lat_cnt_q <= '0;
            read_en_q <= 1'b1;
            state_q   <= DRAIN;
          end else if (pop) begin
            en_q       <= 1'b1;
            ch0_q      <= fifo_rdata[63:0];
            ch1_q      <= fifo_rdata[127:64];
            ch2_q      <= fifo_rdata[191:128];
            ch3_q      <= fifo_rdata[255:192];
            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
          end
        end
        DRAIN: begin
          if (lat_cnt_q == LAT_LAST) begin
            read_en_q   <= 1'b0;
            res_data_q  <= dot_product;
            res_valid_q <= 1'b1;
            state_q     <= RESULT;
          end else begin
            lat_cnt_q <= lat_cnt_q + LW'(1);
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready      = !full;
  assign busy          = (state_q != IDLE);
  assign DMA_channel_0 = ch0_q;
  assign DMA_channel_1 = ch1_q;
  assign DMA_channel_2 = ch2_q;
  assign DMA_channel_3 = ch3_q;
  assign en            = en_q;
  assign clr           = clr_q;
  assign read_en       = read_en_q;
  assign bias          = bias_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;

endmodule

// File: tb/tb_mac_stream_feeder.sv
// tb/tb_mac_stream_feeder.sv - directed self-checking bench for mac_stream_feeder
module tb_mac_stream_feeder;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         start;
  logic [15:0]  vec_len;
  logic [15:0]  bias_in;
  logic         busy;
  logic [63:0]  ch0, ch1, ch2, ch3;
  logic         en, clr, read_en;
  logic [15:0]  bias;
  logic [15:0]  dot_product;
  logic         res_valid;
  logic         res_ready;
  logic [15:0]  res_data;

  int checks = 0;
  int errors = 0;

  mac_stream_feeder #(.FIFO_DEPTH(8), .LEN_W(16), .MAC_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .start(start), .vec_len(vec_len), .bias_in(bias_in), .busy(busy),
    .DMA_channel_0(ch0), .DMA_channel_1(ch1), .DMA_channel_2(ch2), .DMA_channel_3(ch3),
    .en(en), .clr(clr), .read_en(read_en), .bias(bias),
    .dot_product(dot_product),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC array model: accumulates the low 16 bits of every lane per en beat, adds bias
  logic [15:0] acc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc_q <= '0;
    else if (clr) acc_q <= '0;
    else if (en)  acc_q <= acc_q + ch0[15:0] + ch1[15:0] + ch2[15:0] + ch3[15:0];
  end
  assign dot_product = acc_q + bias;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [255:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic kick(input logic [15:0] len, input logic [15:0] b);
    start   = 1'b1;
    vec_len = len;
    bias_in = b;
    step();
    start   = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic wait_res(output int n_en, output bit ok);
    n_en = 0;
    ok   = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (res_valid) ok = 1'b1;
      else begin
        if (en) n_en++;
        step();
      end
    end
  endtask

  task automatic run_basic(input string t);
    for (int i = 0; i < 4; i++) push({192'd0, 64'd1});
    kick(16'd4, 16'd0);
    chk({t, "clr_hi"}, clr, 1);
    chk({t, "en_lo_clear"}, en, 0);
    chk({t, "busy"}, busy, 1);
    step();
    chk({t, "clr_one_cycle"}, clr, 0);
    chk({t, "en_lo_c1"}, en, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk({t, "en_beat"}, en, 1);
      chk({t, "ch0_beat"}, ch0, 64'd1);
    end
    step();
    chk({t, "en_off"}, en, 0);
    chk({t, "read_en_1"}, read_en, 1);
    step();
    chk({t, "read_en_2"}, read_en, 1);
    chk({t, "no_valid_yet"}, res_valid, 0);
    step();
    chk({t, "read_en_off"}, read_en, 0);
    chk({t, "res_valid"}, res_valid, 1);
    chk({t, "res_data"}, res_data, 16'd4);
    handshake();
    chk({t, "valid_drop"}, res_valid, 0);
    chk({t, "idle"}, busy, 0);
  endtask

  int n_en;
  bit ok;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; start = 1'b0;
    vec_len = '0; bias_in = '0; res_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_en", en, 0);
    chk("rst_clr", clr, 0);
    chk("rst_read_en", read_en, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_bias", bias, 0);
    chk("rst_ch0", ch0, 0);
    rst_n = 1'b1;
    step();

    // 1: pre-filled basic dot product
    run_basic("t1_");

    // 2: underrun with 2-cycle gaps between pushes
    kick(16'd3, 16'd5);
    step();
    chk("t2_en_empty", en, 0);
    for (int b = 0; b < 3; b++) begin
      push({128'd0, 64'd2, 64'(b + 1)});
      chk("t2_en_push", en, 0);
      step();
      chk("t2_en_pop", en, 1);
      chk("t2_ch0_pop", ch0, 64'(b + 1));
      step();
      chk("t2_en_gap1", en, 0);
      chk("t2_ch0_hold1", ch0, 64'(b + 1));
      step();
      chk("t2_en_gap2", en, 0);
      chk("t2_ch1_hold2", ch1, 64'd2);
    end
    wait_res(n_en, ok);
    chk("t2_res_seen", ok, 1);
    chk("t2_no_extra_en", n_en, 0);
    chk("t2_res_data", res_data, 16'd17);
    handshake();

    // 3: FIFO full then drained by a vec_len=8 product
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) chk("t3_ready_before_8th", in_ready, 1);
      push({64'(k), 192'd0});
    end
    chk("t3_full", in_ready, 0);
    kick(16'd8, 16'd0);
    chk("t3_full_clear", in_ready, 0);
    step();
    chk("t3_full_c1", in_ready, 0);
    step();
    chk("t3_first_en", en, 1);
    chk("t3_ready_after_pop", in_ready, 1);
    chk("t3_ch3_first", ch3, 64'd1);
    wait_res(n_en, ok);
    chk("t3_res_seen", ok, 1);
    chk("t3_en_count", n_en, 8);
    chk("t3_res_data", res_data, 16'd36);
    handshake();

    // 4: zero-length product returns bias only
    kick(16'd0, 16'h0010);
    chk("t4_clr", clr, 1);
    step();
    chk("t4_clr_off", clr, 0);
    chk("t4_en", en, 0);
    chk("t4_read_en", read_en, 1);
    step();
    chk("t4_read_en2", read_en, 1);
    chk("t4_en2", en, 0);
    step();
    chk("t4_res_valid", res_valid, 1);
    chk("t4_read_en_off", read_en, 0);
    chk("t4_res_data", res_data, 16'h0010);
    handshake();

    // 5: result back-pressure, start ignored while busy and in the handshake cycle
    push({192'd0, 64'd3});
    push({192'd0, 64'd4});
    kick(16'd2, 16'd1);
    wait_res(n_en, ok);
    chk("t5_res_seen", ok, 1);
    chk("t5_en_count", n_en, 2);
    chk("t5_res_data", res_data, 16'd8);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start = 1'b1; vec_len = 16'd1; bias_in = 16'h00ff;
      end
      step();
      start = 1'b0;
      chk("t5_hold_valid", res_valid, 1);
      chk("t5_hold_data", res_data, 16'd8);
    end
    res_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    res_ready = 1'b0;
    chk("t5_valid_drop", res_valid, 0);
    chk("t5_idle", busy, 0);
    step();
    chk("t5_start_ignored_busy", busy, 0);
    chk("t5_start_ignored_clr", clr, 0);

    // 6: reset mid-STREAM drops state and FIFO contents
    for (int i = 0; i < 4; i++) push({192'd0, 64'h00aa});
    kick(16'd4, 16'd0);
    step();
    step();
    chk("t6_streaming", en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_en", en, 0);
    chk("t6_rst_clr", clr, 0);
    chk("t6_rst_read_en", read_en, 0);
    chk("t6_rst_res_valid", res_valid, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    chk("t6_rst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();
    run_basic("t6_");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
